wireframe_scanout: RTL and testbench
====================================

// Module: wireframe_scanout
// PURPOSE
//  Reader side of the wireframe buffer that the line rasterizer fills.
//  On start, walks the whole WIDTH x HEIGHT 1-bit buffer in row-major order:
//  addr = y*WIDTH + x, the same mapping the rasterizer writes with.
//  Emits one pixel per accepted beat on a valid/ready stream toward display/compositing.
//  Optionally clears each location behind the read so the buffer is empty for the next frame.
// PARAMETERS
//  H_PIX          WIDTH                  pixels per row (from defines_package)
//  V_PIX          HEIGHT                 rows per frame (from defines_package)
//  ADDR_W         WIREFRAME_ADDR_SIZE    buffer address width
//  CLEAR_ON_READ  1                      1: write 0 back to every location after it is read
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  n_rst      in   1       reset, synchronous, active-low
//  start      in   1       one-cycle request to scan one frame
//  rd_en      out  1       buffer read strobe
//  rd_addr    out  ADDR_W  buffer read address
//  rd_data    in   1       buffer read data, valid exactly 1 cycle after rd_en
//  clr_en     out  1       buffer write strobe (write data is constant 0)
//  clr_addr   out  ADDR_W  buffer write address
//  pix_valid  out  1       pixel beat available
//  pix_ready  in   1       downstream accepts beat when pix_valid & pix_ready
//  pix_data   out  1       wireframe bit of current pixel
//  pix_sof    out  1       current beat is pixel (0,0)
//  pix_eol    out  1       current beat is last pixel of a row (x == H_PIX-1)
//  busy       out  1       high from the cycle after start through done
//  done       out  1       one-cycle pulse after last pixel accepted
// BEHAVIOUR
//  - Reset (n_rst==0 at clk edge):
//    - state IDLE; FIFO and in-flight flag cleared.
//    - all outputs 0: rd_*, clr_*, pix_*, busy, done.
//  - Reset mid-frame aborts immediately; no done pulse. Next start rescans from address 0.
//  - FSM states:
//    - IDLE: start -> SCAN; linear address counter, x and y cleared.
//    - SCAN: issues reads; -> DRAIN once the read of address H_PIX*V_PIX-1 is issued.
//    - DRAIN: -> DONE when the FIFO is empty and no read is in flight.
//    - DONE: done=1 for one cycle, -> IDLE.
//  - start is ignored in SCAN, DRAIN and DONE. start in the DONE cycle is also ignored.
//  - Read issue: rd_en=1 in SCAN only when (FIFO count + in-flight) < 2. This guarantees no overflow.
//  - rd_addr increments by 1 per issued read, with no multiplier. x and y counters track it:
//    - x wraps H_PIX-1 -> 0 and increments y.
//  - Return path: rd_data is captured 1 cycle after rd_en into a 2-entry FIFO.
//    - Each entry is {data, sof, eol}.
//    - sof and eol are computed at issue time and delayed alongside the read.
//  - Stream: pix_* driven from the FIFO head.
//    - pix_valid = FIFO not empty.
//    - Head pops on valid & ready.
//    - While valid & !ready, pix_data, pix_sof and pix_eol hold stable.
//  - Throughput: 1 pixel/cycle sustained with pix_ready tied high.
//  - Latency: first pix_valid 2 cycles after the start cycle.
//  - Clear (CLEAR_ON_READ=1): clr_en=1 in the cycle rd_data returns, clr_addr = that read's address.
//    - A clear never targets an address that is still to be read.
//  - CLEAR_ON_READ=0: clr_en is tied 0.
//  - Frame size: H_PIX*V_PIX must be <= 2**ADDR_W. Last address is H_PIX*V_PIX-1; no wrap past it.
//  - done pulses exactly once per frame: the cycle after the final beat (sof==0, eol==1, y==V_PIX-1) is accepted.
// STRUCTURE
//  - defines_package: WIDTH, HEIGHT, WIREFRAME_ADDR_SIZE (existing).
//  - Add to defines_package: typedef struct packed {logic data, sof, eol;} WfPixel.
//  - Local enum ScanState {IDLE, SCAN, DRAIN, DONE}.
//  - One sub-module, wf_skid_fifo: 2-deep WfPixel FIFO with push/pop/count. The FIFO has no other consumers.
// TESTING
//  - Use an H_PIX=4, V_PIX=3 model RAM with 1-cycle latency, preloaded pattern.
//  1. pix_ready=1, start:
//     - 12 beats at 1/cycle, data matches RAM in order.
//     - sof on beat 0; eol on beats 3, 7, 11.
//     - done exactly 1 cycle after beat 11 is accepted.
//  2. Random pix_ready at 30% duty:
//     - Same 12-beat sequence; no drop or duplicate.
//     - Outputs stable while stalled; rd_en never makes FIFO+in-flight exceed 2.
//  3. CLEAR_ON_READ=1:
//     - clr_addr sequence is 0..11, each 1 cycle after the matching rd_addr.
//     - RAM is all-zero after done.
//  4. CLEAR_ON_READ=0: clr_en never asserted; RAM unchanged after done.
//  5. Mid-frame conditions:
//     - start pulsed mid-frame and in the DONE cycle: ignored, exactly one done.
//     - A new start after return to IDLE rescans from address 0.
//  6. n_rst=0 asserted at beat 5: all outputs 0 next edge.
//     - After release, start gives a full 12-beat frame beginning at sof.

Source files
------------

// File: rtl/wireframe_scanout_pkg.sv
// Shared definitions for the wireframe buffer: frame geometry, buffer
// address width and the pixel record carried from buffer to stream.
package wireframe_scanout_pkg;

    localparam int WIDTH               = 640;
    localparam int HEIGHT              = 480;
    localparam int WIREFRAME_ADDR_SIZE = 19;

    typedef struct packed {
        logic data;
        logic sof;
        logic eol;
    } WfPixel;

endpackage

// File: rtl/wireframe_scanout_fifo.sv
// Two-entry FIFO of WfPixel records between the buffer read return and the
// output stream. Its head drives the pixel beat directly.
module wireframe_scanout_fifo
    import wireframe_scanout_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       push,
    input  logic       pop,
    input  WfPixel     din,
    output WfPixel     dout,
    output logic [1:0] count
);

    WfPixel mem [2];
    logic   wr_ptr;
    logic   rd_ptr;
    logic   do_push;
    logic   do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    // An empty FIFO presents an all-zero head so the stream fields idle low.
    assign dout = (count != 2'd0) ? mem[rd_ptr] : '0;

    // Storage needs no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/wireframe_scanout.sv
// Reader side of the wireframe buffer: scans the whole frame in row-major
// order, streams one pixel per accepted beat and optionally clears each
// location after it has been read.
module wireframe_scanout
    import wireframe_scanout_pkg::*;
#(
    parameter int H_PIX         = WIDTH,
    parameter int V_PIX         = HEIGHT,
    parameter int ADDR_W        = WIREFRAME_ADDR_SIZE,
    parameter bit CLEAR_ON_READ = 1'b1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_data,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_data,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} ScanState;

    localparam int                XW        = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int                YW        = (V_PIX > 1) ? $clog2(V_PIX) : 1;
    localparam logic [XW-1:0]     LAST_X    = XW'(H_PIX - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIX * V_PIX - 1);

    ScanState          state;
    logic [ADDR_W-1:0] addr;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic              inflight;
    logic [ADDR_W-1:0] inf_addr;
    logic              inf_sof;
    logic              inf_eol;
    logic              issue;
    logic              pop;
    logic [1:0]        occ;
    logic [1:0]        fifo_count;
    WfPixel            fifo_din;
    WfPixel            fifo_head;

    // The beat leaving this cycle frees its slot, so counting it keeps the
    // scan at one pixel per cycle while still never exceeding two entries.
    assign pop   = pix_valid && pix_ready;
    assign occ   = fifo_count - 2'(pop) + 2'(inflight);
    assign issue = (state == SCAN) && (occ < 2'd2);

    assign rd_en    = issue;
    assign rd_addr  = issue ? addr : '0;
    assign clr_en   = CLEAR_ON_READ && inflight;
    assign clr_addr = clr_en ? inf_addr : '0;

    assign fifo_din = '{data: rd_data, sof: inf_sof, eol: inf_eol};

    assign pix_valid = (fifo_count != 2'd0);
    assign pix_data  = fifo_head.data;
    assign pix_sof   = fifo_head.sof;
    assign pix_eol   = fifo_head.eol;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    wireframe_scanout_fifo u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (inflight),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_head),
        .count (fifo_count)
    );

    // Scan FSM with the address/x/y walk and the one-deep in-flight record
    // that pairs each returning read with its address and row flags.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= IDLE;
            addr     <= '0;
            x        <= '0;
            y        <= '0;
            inflight <= 1'b0;
            inf_addr <= '0;
            inf_sof  <= 1'b0;
            inf_eol  <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inf_addr <= addr;
                inf_sof  <= (x == '0) && (y == '0);
                inf_eol  <= (x == LAST_X);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SCAN;
                        addr  <= '0;
                        x     <= '0;
                        y     <= '0;
                    end
                end
                SCAN: begin
                    if (issue) begin
                        if (addr == LAST_ADDR) begin
                            state <= DRAIN;
                        end else begin
                            addr <= addr + ADDR_W'(1);
                            if (x == LAST_X) begin
                                x <= '0;
                                y <= y + YW'(1);
                            end else begin
                                x <= x + XW'(1);
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (!inflight && ((fifo_count == 2'd0) ||
                                      ((fifo_count == 2'd1) && pop))) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wireframe_scanout.sv
// Self-checking bench for wireframe_scanout on a 4x3 frame. Two instances
// share stimulus: one clears behind the read, the other leaves its RAM intact.
module tb_wireframe_scanout;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int N  = H * V;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          n_rst;
    logic          start;
    logic          pix_ready;
    logic          rd_en, clr_en, rd_data;
    logic [AW-1:0] rd_addr, clr_addr;
    logic          pix_valid, pix_data, pix_sof, pix_eol, busy, done;
    logic          nc_rd_en, nc_clr_en, nc_rd_data;
    logic [AW-1:0] nc_rd_addr, nc_clr_addr;
    logic          nc_pix_valid, nc_pix_data, nc_pix_sof, nc_pix_eol, nc_busy, nc_done;

    logic [15:0] ram_a, ram_b, load_pat;
    logic        ram_load;

    int          total, passed, failed, cyc;
    logic [2:0]  exp_q [$];
    int          exp_addr, issued, accepted, done_total, done_beats;
    int          first_acc_cyc, last_acc_cyc, nc_clr_cnt;
    logic        prev_rd_en, prev_stall;
    logic [AW-1:0] prev_rd_addr;
    logic [2:0]  prev_pix, last_beat, obs_pix, exp_pix;

    wireframe_scanout #(.H_PIX(H), .V_PIX(V), .ADDR_W(AW), .CLEAR_ON_READ(1'b1)) dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .clr_en(clr_en), .clr_addr(clr_addr),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .busy(busy), .done(done)
    );

    wireframe_scanout #(.H_PIX(H), .V_PIX(V), .ADDR_W(AW), .CLEAR_ON_READ(1'b0)) dut_nc (
        .clk(clk), .n_rst(n_rst), .start(start),
        .rd_en(nc_rd_en), .rd_addr(nc_rd_addr), .rd_data(nc_rd_data),
        .clr_en(nc_clr_en), .clr_addr(nc_clr_addr),
        .pix_valid(nc_pix_valid), .pix_ready(pix_ready), .pix_data(nc_pix_data),
        .pix_sof(nc_pix_sof), .pix_eol(nc_pix_eol), .busy(nc_busy), .done(nc_done)
    );

    // Model buffers with one cycle of read latency and a zero-write port.
    always @(posedge clk) begin
        if (ram_load) begin
            ram_a <= load_pat;
            ram_b <= load_pat;
        end else begin
            if (clr_en)    ram_a[clr_addr]    <= 1'b0;
            if (nc_clr_en) ram_b[nc_clr_addr] <= 1'b0;
        end
        if (rd_en)    rd_data    <= ram_a[rd_addr];
        if (nc_rd_en) nc_rd_data <= ram_b[nc_rd_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle observation at the falling edge: scoreboard pops, clear
    // timing, stall stability, read address order and occupancy bound.
    task automatic monitorStep();
        cyc++;
        if (!n_rst) begin
            prev_rd_en = 1'b0;
            prev_stall = 1'b0;
            issued     = 0;
            accepted   = 0;
            exp_addr   = 0;
            return;
        end
        if (nc_clr_en) nc_clr_cnt++;
        obs_pix = {pix_data, pix_sof, pix_eol};
        checkOutput("clr_en_follows_read", clr_en, prev_rd_en);
        if (prev_rd_en) checkOutput("clr_addr", clr_addr, prev_rd_addr);
        if (prev_stall) begin
            checkOutput("stall_valid", pix_valid, 1);
            checkOutput("stall_hold", obs_pix, prev_pix);
        end
        if (rd_en) begin
            checkOutput("rd_addr", rd_addr, exp_addr);
            exp_addr++;
            issued++;
        end
        if (pix_valid && pix_ready) begin
            checkOutput("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_pix = exp_q.pop_front();
                checkOutput("beat", obs_pix, exp_pix);
            end
            accepted++;
            if (accepted == 1) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
            last_beat    = obs_pix;
        end
        checkOutput("occupancy_le_2", (issued - accepted) <= 2, 1);
        if (done) begin
            done_total++;
            done_beats = accepted;
            checkOutput("done_timing", cyc - last_acc_cyc, 1);
            checkOutput("done_last_beat_flags", last_beat[1:0], 2'b01);
        end
        if (!busy) begin
            exp_addr = 0;
            issued   = 0;
            accepted = 0;
        end
        prev_rd_en   = rd_en;
        prev_rd_addr = rd_addr;
        prev_stall   = pix_valid && !pix_ready;
        prev_pix     = obs_pix;
    endtask

    task automatic loadFrame(input logic [11:0] pat);
        load_pat = {4'h0, pat};
        ram_load = 1'b1;
        @(posedge clk); #1;
        ram_load = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp_q.push_back({pat[i], (i == 0), ((i % H) == H - 1)});
        end
    endtask

    // Runs one frame: load, start, optional latency probe, optional stray
    // starts mid-frame and in the done cycle, then end-of-frame checks.
    task automatic applyStimulus(input logic [11:0] pat, input bit rnd, input bit poke, input bit chk_lat);
        bit saw_done;
        int n;
        int done_before;
        loadFrame(pat);
        nc_clr_cnt  = 0;
        done_before = done_total;
        pix_ready   = 1'b1;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (chk_lat) begin
            checkOutput("lat_busy", busy, 1);
            checkOutput("lat_valid_c0", pix_valid, 0);
            @(posedge clk); #1;
            checkOutput("lat_valid_c1", pix_valid, 0);
            @(posedge clk); #1;
            checkOutput("lat_valid_c2", pix_valid, 1);
        end
        saw_done = 1'b0;
        n = 0;
        while (!saw_done && n < 400) begin
            if (done) begin
                saw_done = 1'b1;
                start    = poke;
            end else begin
                start = poke && (n == 5);
            end
            pix_ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        start     = 1'b0;
        pix_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("frame_no_timeout", saw_done, 1);
        checkOutput("frame_done_count", done_total - done_before, 1);
        checkOutput("frame_beats", done_beats, N);
        checkOutput("frame_queue_empty", exp_q.size(), 0);
        checkOutput("frame_idle_after", {busy, nc_busy}, 0);
        checkOutput("ram_cleared", ram_a, 0);
        checkOutput("ram_kept", ram_b, {4'h0, pat});
        checkOutput("no_clear_when_off", nc_clr_cnt, 0);
    endtask

    initial begin
        int n;
        total = 0; passed = 0; failed = 0; cyc = 0;
        done_total = 0; done_beats = 0; nc_clr_cnt = 0;
        first_acc_cyc = 0; last_acc_cyc = 0;
        prev_rd_en = 1'b0; prev_stall = 1'b0; prev_rd_addr = '0;
        prev_pix = '0; last_beat = '0;
        issued = 0; accepted = 0; exp_addr = 0;
        n_rst = 1'b0; start = 1'b0; pix_ready = 1'b0;
        ram_load = 1'b0; load_pat = '0;
        fork
            forever begin
                @(negedge clk);
                monitorStep();
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs",
                    {rd_en, rd_addr, clr_en, clr_addr, pix_valid, pix_data, pix_sof, pix_eol, busy, done}, 0);
        n_rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] frame with ready held high");
        applyStimulus(12'hA5C, 1'b0, 1'b0, 1'b1);
        checkOutput("throughput", last_acc_cyc - first_acc_cyc, N - 1);

        $display("[TB] frames with 30%% ready duty");
        applyStimulus(12'h3B6, 1'b1, 1'b0, 1'b0);
        applyStimulus(12'hE19, 1'b1, 1'b0, 1'b0);

        $display("[TB] stray starts mid-frame and during done, then rescan");
        applyStimulus(12'h69E, 1'b1, 1'b1, 1'b0);
        applyStimulus(12'h5A3, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset at beat 5");
        loadFrame(12'hB4D);
        pix_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (accepted < 5 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("rst_reached_beat5", accepted >= 5, 1);
        checkOutput("rst_busy_before", busy, 1);
        n_rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_outputs_zero",
                    {rd_en, rd_addr, clr_en, clr_addr, pix_valid, pix_data, pix_sof, pix_eol, busy, done}, 0);
        n_rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        checkOutput("rst_no_done", done, 0);
        applyStimulus(12'hC71, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
